mealy_pattern_detector: RTL

Parametrised Mealy serial-pattern detector, next generation of the fixed zero-after-ones detector.
- Detects a runtime-programmable bit pattern of length 1..MAX_LEN on a qualified serial stream.
- Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
- Sits between a serial front-end and status/interrupt logic; with the pattern "10" in overlap mode it reproduces the legacy zero-detector output.

---
 rtl/mealy_det_pkg.sv | 22 ++
 rtl/det_sat_counter.sv | 31 +++
 rtl/mealy_pattern_detector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mealy_det_pkg.sv
// rtl/mealy_det_pkg.sv - shared states, defaults and masked compare for mealy_pattern_detector
package mealy_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FILL = 2'b01,
        S_HUNT = 2'b10
    } det_state_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    // Compares the low len bits of window and pattern; callers zero-extend to 32 bits.
    function automatic logic masked_eq(input logic [31:0] window,
                                       input logic [31:0] pat,
                                       input logic [5:0]  len);
        logic [31:0] mask;
        mask = (len >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        return ((window ^ pat) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/det_sat_counter.sv
// rtl/det_sat_counter.sv - saturating up-counter with synchronous active-low clear
module det_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mealy_pattern_detector.sv
// rtl/mealy_pattern_detector.sv - programmable Mealy serial pattern detector; MEALY_DET_HOLD_EN adds y_hold/hold_clr
module mealy_pattern_detector
    import mealy_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               x_in,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y_out,
    output logic               armed,
    output logic [CNT_W-1:0]   match_count,
`ifdef MEALY_DET_HOLD_EN
    input  logic               hold_clr,
    output logic               y_hold,
`endif
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    det_state_e         state_q, state_d;
    // The oldest history bit never reaches the compare window, so it is not stored.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               cfg_err_q;
    logic               armed_q;
    logic               cfg_legal;
    logic               hit;
    logic [MAX_LEN-1:0] window;

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    assign window    = {hist_q, x_in};
    assign hit       = masked_eq(32'(window), 32'(pat_q), 6'(len_q));

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        y_out   = 1'b0;
        if (cfg_load) begin
            if (cfg_legal) begin
                pat_d   = cfg_pat;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = (cfg_len == ONE_L) ? S_HUNT : S_FILL;
            end
        end else if (x_valid) begin
            unique case (state_q)
                S_IDLE: ;
                S_FILL: begin
                    hist_d = {hist_q[MAX_LEN-3:0], x_in};
                    fill_d = fill_q + ONE_L;
                    if (fill_q + ONE_L == len_q - ONE_L) begin
                        state_d = S_HUNT;
                    end
                end
                S_HUNT: begin
                    y_out = hit;
                    if (hit && !ovl_q) begin
                        hist_d = '0;
                        fill_d = '0;
                        if (len_q != ONE_L) begin
                            state_d = S_FILL;
                        end
                    end else begin
                        hist_d = {hist_q[MAX_LEN-3:0], x_in};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_load && !cfg_legal;
            armed_q   <= (state_d == S_HUNT);
        end
    end

    det_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clock (clock),
        .clr_n (reset),
        .inc   (y_out),
        .count (match_count)
    );

`ifdef MEALY_DET_HOLD_EN
    logic y_hold_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            y_hold_q <= 1'b0;
        end else if (y_out) begin
            y_hold_q <= 1'b1;
        end else if (hold_clr) begin
            y_hold_q <= 1'b0;
        end
    end

    assign y_hold = y_hold_q;
`endif

    assign armed   = armed_q;
    assign cfg_err = cfg_err_q;

endmodule
